// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package display_pkg;

  localparam int CODE_W = 5;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

  typedef logic [CODE_W-1:0] digit_code_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_dwell_timer.sv
// Down-counter timing one dwell phase; load sets it to length-1 and done is high at zero.
module display_dwell_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] length_i,
  output logic               done_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = length_i - TIMER_W'(1);
    end else if (count_q != '0) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans a double-buffered bank of digit codes across NUM_DIGITS displays through one
// shared decoder, with a dark gap before every digit and frame-aligned bank commits.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ADDR_W       = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [CODE_W-1:0]     wr_data,
  input  logic                  commit,
  output logic                  commit_ack,
  output logic                  frame_start,
  output logic [CODE_W-1:0]     code,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  dbg_state
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int TIMER_W = $clog2(max_int(SHOW_CYCLES, BLANK_CYCLES) + 1);
  localparam logic [TIMER_W-1:0] SHOW_LEN  = TIMER_W'(SHOW_CYCLES);
  localparam logic [TIMER_W-1:0] BLANK_LEN = TIMER_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  scan_state_t           state_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  run_q;
  logic                  pending_q;
  digit_code_t           shadow_q [NUM_DIGITS];
  digit_code_t           active_q [NUM_DIGITS];
  digit_code_t           code_q;
  logic [NUM_DIGITS-1:0] dig_en_q;
  logic                  ack_q;
  logic                  frame_q;

  logic [IDX_W-1:0]   idx_next;
  logic               at_wrap;
  logic               do_copy;
  logic               tmr_clear;
  logic               tmr_load;
  logic               tmr_done;
  logic [TIMER_W-1:0] tmr_len;
  digit_code_t        next_code;

  // run_q low means the scan is parked (after reset or while disabled); the first
  // enabled edge from there is treated as a fresh entry into BLANK for digit 0.
  always_comb begin
    idx_next  = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    at_wrap   = enable && run_q && tmr_done && (state_q == ST_SHOW) && (idx_q == LAST_IDX);
    do_copy   = at_wrap && pending_q;
    tmr_clear = !enable;
    tmr_load  = enable && (!run_q || tmr_done);
    tmr_len   = (!run_q || state_q == ST_SHOW) ? BLANK_LEN : SHOW_LEN;
    next_code = active_q[0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        next_code = active_q[i];
      end
    end
  end

  display_dwell_timer #(
    .TIMER_W (TIMER_W)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmr_clear),
    .load_i   (tmr_load),
    .length_i (tmr_len),
    .done_o   (tmr_done)
  );

  // Commit handshake: a commit pulse (any length) latches a request; commit_ack is a
  // single-cycle pulse on the wrap edge that copies shadow into active. The copy uses
  // the shadow as it stood before that edge, and a commit seen on the wrap edge itself
  // is held over to the following wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BLANK;
      idx_q     <= '0;
      run_q     <= 1'b0;
      pending_q <= 1'b0;
      code_q    <= '0;
      dig_en_q  <= '0;
      ack_q     <= 1'b0;
      frame_q   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      ack_q   <= 1'b0;
      frame_q <= 1'b0;

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_en && (wr_addr == ADDR_W'(i))) begin
          shadow_q[i] <= wr_data;
        end
      end

      if (!enable) begin
        state_q  <= ST_BLANK;
        idx_q    <= '0;
        run_q    <= 1'b0;
        dig_en_q <= '0;
        code_q   <= active_q[0];
      end else if (!run_q) begin
        state_q  <= ST_BLANK;
        idx_q    <= '0;
        run_q    <= 1'b1;
        dig_en_q <= '0;
        code_q   <= active_q[0];
      end else if (tmr_done) begin
        case (state_q)
          ST_BLANK: begin
            state_q  <= ST_SHOW;
            dig_en_q <= NUM_DIGITS'(1) << idx_q;
          end
          default: begin
            state_q  <= ST_BLANK;
            idx_q    <= idx_next;
            dig_en_q <= '0;
            code_q   <= next_code;
            frame_q  <= at_wrap;
            if (do_copy) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                active_q[i] <= shadow_q[i];
              end
              code_q <= shadow_q[0];
              ack_q  <= 1'b1;
            end
          end
        endcase
      end

      if (do_copy) begin
        pending_q <= 1'b0;
      end
      if (commit) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign commit_ack  = ack_q;
  assign frame_start = frame_q;
  assign code        = code_q;
  assign dig_en      = dig_en_q;
  assign dbg_state   = (state_q == ST_SHOW);

endmodule
